cyclic_serial_encoder: RTL and testbench
========================================

# cyclic_serial_encoder

- Parametrised, systematic, bit-serial (N,K) cyclic-code encoder built on a generic LFSR divider.
- Generalises the fixed 4-stage parity register with:
  - a configurable generator polynomial and code length;
  - valid/ready flow control on input and output;
  - framing flags and a synchronous flush.
- Sits between the bit source and the channel model, ahead of the majority-logic decoder.
- Emits K information bits unchanged, followed by R = N-K parity bits.

## Interface

**Parameters**

- N, default 7: codeword length in bits.
- K, default 3: information bits per codeword. Constraints:
  - 1 <= K < N;
  - R = N-K.
- GEN_POLY, default 5'b11101: generator polynomial coefficients, R+1 bits, bit i = g_i. The default is g(x) = 1+x^2+x^3+x^4.
  - GEN_POLY[0] must be 1.
  - GEN_POLY[R] must be 1.
  - Elaboration fails otherwise.

**Ports** (clock and reset first)

- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous abort of the current codeword.
- in_valid, input, 1: in_bit is valid.
- in_ready, output, 1: encoder accepts in_bit this cycle.
- in_bit, input, 1: information bit, highest-degree bit first.
- out_valid, output, 1: out_bit is valid.
- out_ready, input, 1: downstream accepts out_bit.
- out_bit, output, 1: serial codeword bit.
- out_is_parity, output, 1: out_bit is a parity bit.
- out_last, output, 1: out_bit is the final bit of the codeword.

## Operation

**Internal state**

- LFSR r[R-1:0].
- State register, with states DATA and PARITY.
- Bit counter cnt of width $clog2(max(K,R)+1).
- One-entry output register holding out_bit, out_is_parity and out_last.

**Output register**

- free = !out_valid || out_ready.
- The register loads only when free.

**DATA state**

- in_ready = free && !flush.
- On acceptance (in_valid && in_ready):
  - out_bit <= in_bit, out_is_parity <= 0, out_last <= 0, out_valid <= 1.
  - fb = r[R-1] ^ in_bit.
  - r[0] <= fb.
  - r[i] <= r[i-1] ^ (fb & GEN_POLY[i]) for i = 1..R-1.
  - cnt++.
- On the K-th acceptance: cnt <= 0 and the state moves to PARITY.

**PARITY state**

- in_ready = 0.
- Each cycle where free:
  - out_bit <= r[R-1], out_is_parity <= 1, out_valid <= 1.
  - r <= r << 1, with zero shifted in.
  - cnt++.
- On the R-th parity bit:
  - out_last <= 1.
  - The state returns to DATA with cnt <= 0.
  - r is all-zero at this point by construction.

**Idle output**

- When free and nothing is loaded, out_valid <= 0.

**Bit order on the wire**

- Information bits u_{K-1}..u_0 are sent first.
- Parity bits p_{R-1}..p_0 follow, where p(x) = x^R u(x) mod g(x).

**flush**

- Has priority over every handshake.
- Next edge: r <= 0, cnt <= 0, state <= DATA, out_valid <= 0, and out_last and out_is_parity are cleared.
- The pending out_bit is discarded.

**reset**

- Same effect as flush, but asynchronous.
- Outputs after reset:
  - out_valid = 0, out_bit = 0, out_is_parity = 0, out_last = 0.
  - in_ready = 1 while flush is 0.

## Timing

- Latency: out_bit is valid one cycle after input acceptance, or one cycle after the parity-load edge.
- Throughput, with out_ready held at 1: one bit per cycle, one codeword every N cycles.
  - in_ready is high for K cycles.
  - in_ready is low for R cycles.
- Backpressure:
  - out_ready = 0 while out_valid = 1 holds out_bit, flags and r stable.
  - in_ready is 0 during backpressure.
  - There are no bubbles when out_ready returns.
- The transition from the last parity bit to the first bit of the next codeword happens with no idle cycle.
- in_valid dropping mid-codeword stalls DATA with no state loss.
- The PARITY phase proceeds regardless of in_valid.
- Reset or flush mid-PARITY abandons the remaining parity bits. The next accepted bit starts a fresh codeword.

## Configuration

- Macro: CYC_ENC_PARALLEL_OUT_EN.
- When defined, two extra outputs are added:
  - parity_vector [R-1:0], registered and reset to 0;
  - parity_valid, 1 bit, reset to 0.
- On the edge that accepts the K-th information bit:
  - parity_vector <= the updated LFSR value;
  - parity_valid pulses high for exactly one cycle.
- flush clears parity_vector and parity_valid.
- When not defined, both ports and their registers are absent. Serial behaviour is identical in both builds.

## Test plan

- **Reset:** assert reset asynchronously mid-cycle. Required:
  - out_valid = 0 immediately;
  - in_ready = 1 after release.
- **Single codeword, u = 1,0,0, out_ready held at 1.** Required:
  - serial output 1,0,0,1,1,1,0;
  - out_is_parity = 0,0,0,1,1,1,1;
  - out_last only on the 7th bit;
  - in_ready low for 4 cycles.
- **Back-to-back codewords u = 1,1,1 then 1,0,0.** Required:
  - output 1,1,1,0,1,0,0 followed by 1,0,0,1,1,1,0;
  - 14 consecutive valid cycles with no bubble.
- **Backpressure:** drive out_ready = 0 for 3 cycles during the parity bit p2 of u = 1,0,0. Required:
  - out_bit holds at 1;
  - the sequence resumes unchanged.
- **Flush after 2 parity bits.** Required:
  - out_valid = 0 on the next cycle;
  - a following u = 1,1,1 encodes to 1,1,1,0,1,0,0.
- **CYC_ENC_PARALLEL_OUT_EN build, u = 1,0,0.** Required:
  - parity_vector = 4'b1110;
  - one-cycle parity_valid pulse following the 3rd acceptance.

Source files
------------

// File: rtl/cyclic_serial_encoder_if.sv
// ---------------------------------------------------------------------------
// cyclic_serial_encoder_if
//
// Purpose : groups the serial input and output handshakes of the cyclic
//           serial encoder into a single bundle.
//
// Signals :
//   in_valid       source -> encoder : in_bit is valid
//   in_ready       encoder -> source : encoder accepts in_bit this cycle
//   in_bit         source -> encoder : information bit, highest degree first
//   out_valid      encoder -> sink   : out_bit is valid
//   out_ready      sink -> encoder   : sink accepts out_bit
//   out_bit        encoder -> sink   : serial codeword bit
//   out_is_parity  encoder -> sink   : out_bit is a parity bit
//   out_last       encoder -> sink   : out_bit closes the codeword
//
// Modports:
//   master : the surrounding environment (bit source plus channel sink)
//   slave  : the encoder itself
// ---------------------------------------------------------------------------
interface cyclic_serial_encoder_if;
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_is_parity;
  logic out_last;

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_is_parity,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_is_parity,
    output out_last
  );
endinterface

// File: rtl/cyclic_serial_encoder.sv
// ---------------------------------------------------------------------------
// cyclic_serial_encoder
//
// Purpose : systematic, bit-serial (N,K) cyclic-code encoder. K information
//           bits are forwarded unchanged (highest degree first) while an LFSR
//           divider accumulates x^R u(x) mod g(x); the R = N-K parity bits
//           are then shifted out of the LFSR, highest degree first.
//
// Parameters:
//   N        codeword length
//   K        information bits per codeword (1 <= K < N)
//   GEN_POLY generator polynomial, R+1 bits, bit i = g_i; g_0 and g_R must
//            be 1 (elaboration stops otherwise)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   flush          synchronous abort of the current codeword (highest priority)
//   bus            cyclic_serial_encoder_if.slave handshake bundle
//   parity_vector  [R-1:0] LFSR contents captured on the K-th information bit
//                  (only with CYC_ENC_PARALLEL_OUT_EN)
//   parity_valid   one-cycle strobe qualifying parity_vector
//                  (only with CYC_ENC_PARALLEL_OUT_EN)
//
// Optional feature macro: CYC_ENC_PARALLEL_OUT_EN adds the parallel parity
// outputs. The serial behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module cyclic_serial_encoder #(
  parameter int N = 7,
  parameter int K = 3,
  parameter logic [N-K:0] GEN_POLY = 5'b11101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  cyclic_serial_encoder_if.slave bus
`ifdef CYC_ENC_PARALLEL_OUT_EN
  ,
  output logic [N-K-1:0]        parity_vector,
  output logic                  parity_valid
`endif
);

  localparam int R     = N - K;
  localparam int MAX_C = (K > R) ? K : R;
  localparam int CNT_W = $clog2(MAX_C + 1);

  // Refuse to build an encoder whose shape or generator cannot work.
  generate
    if (K < 1 || K >= N) begin : g_bad_k
      $error("cyclic_serial_encoder: K must satisfy 1 <= K < N");
    end
    if (GEN_POLY[0] != 1'b1 || GEN_POLY[R] != 1'b1) begin : g_bad_poly
      $error("cyclic_serial_encoder: GEN_POLY needs g_0 = 1 and g_R = 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  // One division step of the systematic encoder: the incoming bit is added
  // to the register's top bit and the sum is fed back through the generator
  // taps. g_R is implicit in the feedback, g_0 is the plain r[0] load.
  function automatic logic [R-1:0] lfsr_step(input logic [R-1:0] cur,
                                             input logic         din);
    logic          fb;
    logic [R-1:0]  nxt;
    fb     = cur[R-1] ^ din;
    nxt    = {R{1'b0}};
    nxt[0] = fb;
    for (int i = 1; i < R; i++) begin
      nxt[i] = cur[i-1] ^ (fb & GEN_POLY[i]);
    end
    return nxt;
  endfunction

  // Registered state
  state_t             state_r;
  logic [R-1:0]       lfsr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               out_valid_r;
  logic               out_bit_r;
  logic               out_is_parity_r;
  logic               out_last_r;

  // Next-state values
  state_t             state_s;
  logic [R-1:0]       lfsr_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               out_valid_s;
  logic               out_bit_s;
  logic               out_is_parity_s;
  logic               out_last_s;

  logic               free_s;
  logic               in_ready_s;

`ifdef CYC_ENC_PARALLEL_OUT_EN
  logic [R-1:0]       parity_vector_r;
  logic               parity_valid_r;
  logic [R-1:0]       parity_vector_s;
  logic               parity_valid_s;
`endif

  // Next-state and handshake decode: flush first, then the output register
  // may only move when it is empty or being drained this cycle.
  always_comb begin
    free_s          = !out_valid_r || bus.out_ready;
    in_ready_s      = 1'b0;
    state_s         = state_r;
    lfsr_s          = lfsr_r;
    cnt_s           = cnt_r;
    out_valid_s     = out_valid_r;
    out_bit_s       = out_bit_r;
    out_is_parity_s = out_is_parity_r;
    out_last_s      = out_last_r;
`ifdef CYC_ENC_PARALLEL_OUT_EN
    parity_vector_s = parity_vector_r;
    parity_valid_s  = 1'b0;
`endif

    if (flush) begin
      state_s         = ST_DATA;
      lfsr_s          = {R{1'b0}};
      cnt_s           = {CNT_W{1'b0}};
      out_valid_s     = 1'b0;
      out_bit_s       = 1'b0;
      out_is_parity_s = 1'b0;
      out_last_s      = 1'b0;
`ifdef CYC_ENC_PARALLEL_OUT_EN
      parity_vector_s = {R{1'b0}};
      parity_valid_s  = 1'b0;
`endif
    end else if (free_s) begin
      case (state_r)
        ST_DATA: begin
          in_ready_s = 1'b1;
          if (bus.in_valid) begin
            // Information bit goes straight to the wire and into the divider.
            out_bit_s       = bus.in_bit;
            out_is_parity_s = 1'b0;
            out_last_s      = 1'b0;
            out_valid_s     = 1'b1;
            lfsr_s          = lfsr_step(lfsr_r, bus.in_bit);
            if (cnt_r == CNT_W'(K - 1)) begin
              cnt_s   = {CNT_W{1'b0}};
              state_s = ST_PARITY;
`ifdef CYC_ENC_PARALLEL_OUT_EN
              parity_vector_s = lfsr_step(lfsr_r, bus.in_bit);
              parity_valid_s  = 1'b1;
`endif
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            // Nothing new to present; the previous bit has been taken.
            out_valid_s = 1'b0;
          end
        end

        ST_PARITY: begin
          // The remainder leaves highest degree first; zeros refill the
          // register, so it is clear again once all R bits are out.
          out_bit_s       = lfsr_r[R-1];
          out_is_parity_s = 1'b1;
          out_valid_s     = 1'b1;
          lfsr_s          = lfsr_r << 1;
          if (cnt_r == CNT_W'(R - 1)) begin
            out_last_s = 1'b1;
            cnt_s      = {CNT_W{1'b0}};
            state_s    = ST_DATA;
          end else begin
            out_last_s = 1'b0;
            cnt_s      = cnt_r + CNT_W'(1);
          end
        end

        default: begin
          state_s         = ST_DATA;
          lfsr_s          = {R{1'b0}};
          cnt_s           = {CNT_W{1'b0}};
          out_valid_s     = 1'b0;
          out_is_parity_s = 1'b0;
          out_last_s      = 1'b0;
        end
      endcase
    end else begin
      // Downstream is stalling: every register keeps its value.
      state_s = state_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_DATA;
      lfsr_r          <= {R{1'b0}};
      cnt_r           <= {CNT_W{1'b0}};
      out_valid_r     <= 1'b0;
      out_bit_r       <= 1'b0;
      out_is_parity_r <= 1'b0;
      out_last_r      <= 1'b0;
    end else begin
      state_r         <= state_s;
      lfsr_r          <= lfsr_s;
      cnt_r           <= cnt_s;
      out_valid_r     <= out_valid_s;
      out_bit_r       <= out_bit_s;
      out_is_parity_r <= out_is_parity_s;
      out_last_r      <= out_last_s;
    end
  end

`ifdef CYC_ENC_PARALLEL_OUT_EN
  // Parallel snapshot of the remainder taken with the last information bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_vector_r <= {R{1'b0}};
      parity_valid_r  <= 1'b0;
    end else begin
      parity_vector_r <= parity_vector_s;
      parity_valid_r  <= parity_valid_s;
    end
  end

  assign parity_vector = parity_vector_r;
  assign parity_valid  = parity_valid_r;
`endif

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_bit       = out_bit_r;
  assign bus.out_is_parity = out_is_parity_r;
  assign bus.out_last      = out_last_r;

endmodule

// File: tb/tb_cyclic_serial_encoder.sv
// ---------------------------------------------------------------------------
// tb_cyclic_serial_encoder
//
// Self-checking bench for the (7,3) encoder with g(x) = 1+x^2+x^3+x^4.
// Expected codewords come from a table of hand-divided remainders; each
// codeword's bits are queued when its stimulus starts and compared as the
// encoder hands them over. Hand-written sequences cover reset, back-to-back
// framing, backpressure, flush and the optional parallel parity port.
// ---------------------------------------------------------------------------
module tb_cyclic_serial_encoder;
  localparam int N = 7;
  localparam int K = 3;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  cyclic_serial_encoder_if bus ();

`ifdef CYC_ENC_PARALLEL_OUT_EN
  logic [R-1:0] parity_vector;
  logic         parity_valid;
`endif

  cyclic_serial_encoder #(
    .N(N), .K(K), .GEN_POLY(5'b11101)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef CYC_ENC_PARALLEL_OUT_EN
    ,
    .parity_vector (parity_vector),
    .parity_valid  (parity_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic p;
    logic l;
  } exp_t;

  typedef struct {
    logic [K-1:0] u;
    logic [N-1:0] cw;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   par_pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no event, want event within bound", name);
  endtask

  // Queue the N wire bits of one codeword, first bit on the wire first.
  task automatic push_cw(input logic [N-1:0] cw);
    for (int i = N - 1; i >= 0; i--) begin
      sb_q.push_back({cw[i], (i < R) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
    end
  endtask

  // Scoreboard consumer: compares every bit the sink actually takes.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !flush && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_out");
      end else begin
        e = sb_q.pop_front();
        check("sb_bit_par_last", {29'd0, bus.out_bit, bus.out_is_parity, bus.out_last},
              {29'd0, e.b, e.p, e.l});
        if (e.p) par_pops++;
      end
    end
  end

  task automatic send_bit(input logic b);
    int t;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 60) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [K-1:0] u, input bit gaps);
    for (int i = K - 1; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_bit(u[i]);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  low_cnt;
    int  run;
    int  pc;
    int  base;
    int  t;
    bit  done;

    // Remainders of x^4 u(x) mod (1+x^2+x^3+x^4), worked by hand.
    vecs[0] = '{3'b000, 7'b000_0000};
    vecs[1] = '{3'b001, 7'b001_1101};
    vecs[2] = '{3'b010, 7'b010_0111};
    vecs[3] = '{3'b011, 7'b011_1010};
    vecs[4] = '{3'b100, 7'b100_1110};
    vecs[5] = '{3'b101, 7'b101_0011};
    vecs[6] = '{3'b110, 7'b110_1001};
    vecs[7] = '{3'b111, 7'b111_0100};

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_flags", {29'd0, bus.out_bit, bus.out_is_parity, bus.out_last}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single codeword u = 1,0,0; in_ready must drop for exactly R cycles.
    push_cw(vecs[4].cw);
    low_cnt = 0;
    fork
      begin
        send_word(3'b100, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (16) begin
          @(negedge clk);
          if (!bus.in_ready) low_cnt++;
        end
      end
    join
    check("in_ready_low_cycles", low_cnt, 32'd4);
    drain();

    // Back-to-back 1,1,1 then 1,0,0: fourteen valid cycles with no bubble.
    push_cw(vecs[7].cw);
    push_cw(vecs[4].cw);
    run = 0;
    fork
      begin
        send_word(3'b111, 1'b0);
        send_word(3'b100, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 20) begin
          t++;
          @(negedge clk);
        end
        while (bus.out_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
      end
    join
    check("b2b_valid_run", run, 32'd14);
    drain();

    // Backpressure on p2 of u = 1,0,0 for three cycles.
    push_cw(vecs[4].cw);
    fork
      begin
        send_word(3'b100, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        pc = 0;
        t  = 0;
        while (pc < 2 && t < 30) begin
          @(posedge clk);
          #1;
          t++;
          if (bus.out_valid && bus.out_is_parity) pc++;
        end
        if (pc < 2) fail_now("bp_parity_wait");
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_hold_valid_bit", {30'd0, bus.out_valid, bus.out_bit}, 32'd3);
          check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush after two parity bits, then a fresh codeword.
    push_cw(vecs[4].cw);
    base = par_pops;
    fork
      begin
        send_word(3'b100, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        t = 0;
        while (par_pops < base + 2 && t < 30) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (par_pops < base + 2) fail_now("flush_parity_wait");
      end
    join
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb_q.delete();
    check("flush_out_state", {29'd0, bus.out_valid, bus.out_is_parity, bus.out_last}, 32'd0);
    push_cw(vecs[7].cw);
    send_word(3'b111, 1'b0);
    bus.in_valid = 1'b0;
    drain();

`ifdef CYC_ENC_PARALLEL_OUT_EN
    // Parallel remainder snapshot for u = 1,0,0.
    push_cw(vecs[4].cw);
    send_bit(1'b1);
    send_bit(1'b0);
    check("pv_idle", {31'd0, parity_valid}, 32'd0);
    send_bit(1'b0);
    bus.in_valid = 1'b0;
    check("pv_pulse", {31'd0, parity_valid}, 32'd1);
    check("pv_vector", {28'd0, parity_vector}, 32'hE);
    @(posedge clk);
    #1;
    check("pv_pulse_end", {31'd0, parity_valid}, 32'd0);
    drain();
`endif

    // Table: every message, random input gaps and random sink stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          push_cw(vecs[i].cw);
          send_word(vecs[i].u, 1'b1);
        end
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-codeword, then a clean codeword.
    push_cw(vecs[7].cw);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.in_valid = 1'b0;
    check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_out", {28'd0, bus.out_valid, bus.out_bit, bus.out_is_parity, bus.out_last}, 32'd0);
    sb_q.delete();
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    push_cw(vecs[4].cw);
    send_word(3'b100, 1'b0);
    bus.in_valid = 1'b0;
    drain();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
